// File: rtl/charge_ram_ctrl.sv
// Charge RAM sequencer: clears the RAM after reset, then arbitrates accumulate/check
// ops into a 2-stage read-modify-write pipeline. Optional macro: CHARGE_LEAK_EN.
module charge_ram_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 8,
    parameter int LEAK_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [ADDR_W-1:0]          acc_addr,
    input  logic signed [WEIGHT_W-1:0] acc_weight,
    input  logic                       chk_valid,
    output logic                       chk_ready,
    input  logic [ADDR_W-1:0]          chk_addr,
    input  logic signed [DATA_W-1:0]   chk_threshold,
    output logic                       fire_valid,
    output logic [ADDR_W-1:0]          fire_addr,
    output logic                       init_done,
    output logic                       ram_rd_en,
    output logic [ADDR_W-1:0]          ram_rd_addr,
    input  logic signed [DATA_W-1:0]   ram_rd_data,
    output logic                       ram_wr_en,
    output logic [ADDR_W-1:0]          ram_wr_addr,
    output logic signed [DATA_W-1:0]   ram_wr_data
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0]        LAST_ADDR  = '1;
    localparam logic signed [DATA_W-1:0] MAX_CHARGE = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_CHARGE = {1'b1, {(DATA_W-1){1'b0}}};

`ifndef CHARGE_LEAK_EN
    localparam int leak_shift_unused = LEAK_SHIFT;
`endif

    state_t                     state, state_nxt;
    logic [ADDR_W-1:0]          sweep_cnt;
    logic                       rr_chk;

    logic                       acc_grant, chk_grant, contested, accept;
    logic [ADDR_W-1:0]          addr_p0;
    logic                       bypass_p0;

    logic                       vld_p1;
    logic                       op_chk_p1;
    logic                       bypass_p1;
    logic [ADDR_W-1:0]          addr_p1;
    logic signed [WEIGHT_W-1:0] weight_p1;
    logic signed [DATA_W-1:0]   thr_p1;
    logic signed [DATA_W-1:0]   bypass_data_p1;
    logic signed [DATA_W-1:0]   operand_p1;
    logic signed [DATA_W-1:0]   result_p1;
    logic                       fire_p1;

    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0]   a,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [DATA_W:0] sum;
        sum = (DATA_W+1)'(a) + (DATA_W+1)'(w);
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? MIN_CHARGE : MAX_CHARGE;
        return sum[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] retain(input logic signed [DATA_W-1:0] v);
`ifdef CHARGE_LEAK_EN
        return v - (v >>> LEAK_SHIFT);
`else
        return v;
`endif
    endfunction

    // Stage 0: arbitration and RAM read issue
    always_comb begin
        acc_grant = 1'b0;
        chk_grant = 1'b0;
        contested = 1'b0;
        if (reset && state == RUN) begin
            contested = acc_valid && chk_valid;
            if (contested) begin
                chk_grant = rr_chk;
                acc_grant = !rr_chk;
            end else begin
                chk_grant = chk_valid;
                acc_grant = acc_valid;
            end
        end
    end

    assign accept    = acc_grant || chk_grant;
    assign addr_p0   = chk_grant ? chk_addr : acc_addr;
    // The RAM returns the pre-write value when reading the address stage 1 is writing
    assign bypass_p0 = vld_p1 && (addr_p0 == addr_p1);

    always_comb begin
        state_nxt   = state;
        acc_ready   = 1'b0;
        chk_ready   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (reset) begin
            case (state)
                INIT: begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = sweep_cnt;
                    if (sweep_cnt == LAST_ADDR)
                        state_nxt = RUN;
                end
                RUN: begin
                    acc_ready   = acc_grant;
                    chk_ready   = chk_grant;
                    ram_rd_en   = accept;
                    ram_rd_addr = accept ? addr_p0 : '0;
                    ram_wr_en   = vld_p1;
                    ram_wr_addr = vld_p1 ? addr_p1 : '0;
                    ram_wr_data = vld_p1 ? result_p1 : '0;
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= INIT;
            sweep_cnt  <= '0;
            init_done  <= 1'b0;
            rr_chk     <= 1'b1;
            vld_p1     <= 1'b0;
            fire_valid <= 1'b0;
            fire_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
            if (state == INIT && state_nxt == RUN)
                init_done <= 1'b1;
            if (contested)
                rr_chk <= !rr_chk;
            vld_p1     <= accept;
            fire_valid <= vld_p1 && fire_p1;
            if (vld_p1 && fire_p1)
                fire_addr <= addr_p1;
        end
    end

    // Stage 1: operand select, compute, write back
    always_ff @(posedge clk) begin
        op_chk_p1      <= chk_grant;
        addr_p1        <= addr_p0;
        weight_p1      <= acc_weight;
        thr_p1         <= chk_threshold;
        bypass_p1      <= bypass_p0;
        bypass_data_p1 <= result_p1;
    end

    always_comb begin
        operand_p1 = bypass_p1 ? bypass_data_p1 : ram_rd_data;
        fire_p1    = 1'b0;
        result_p1  = sat_add(operand_p1, weight_p1);
        if (op_chk_p1) begin
            fire_p1   = operand_p1 >= thr_p1;
            result_p1 = fire_p1 ? '0 : retain(operand_p1);
        end
    end

endmodule

// File: tb/tb_charge_ram_ctrl.sv
// Bench for charge_ram_ctrl: behavioural charge-array model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_charge_ram_ctrl;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int WEIGHT_W   = 8;
    localparam int LEAK_SHIFT = 2;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int CMAX       = 32767;
    localparam int CMIN       = -32768;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       acc_valid, acc_ready;
    logic [ADDR_W-1:0]          acc_addr;
    logic signed [WEIGHT_W-1:0] acc_weight;
    logic                       chk_valid, chk_ready;
    logic [ADDR_W-1:0]          chk_addr;
    logic signed [DATA_W-1:0]   chk_threshold;
    logic                       fire_valid;
    logic [ADDR_W-1:0]          fire_addr;
    logic                       init_done;
    logic                       ram_rd_en;
    logic [ADDR_W-1:0]          ram_rd_addr;
    logic signed [DATA_W-1:0]   ram_rd_data;
    logic                       ram_wr_en;
    logic [ADDR_W-1:0]          ram_wr_addr;
    logic signed [DATA_W-1:0]   ram_wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    charge_ram_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk(clk), .reset(reset),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr), .acc_weight(acc_weight),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_threshold(chk_threshold),
        .fire_valid(fire_valid), .fire_addr(fire_addr), .init_done(init_done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
    );

    // Read-before-write RAM with a registered read port
    logic signed [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : ((v < CMIN) ? CMIN : v);
    endfunction

    function automatic int keep(input int v);
`ifdef CHARGE_LEAK_EN
        return v - (v >>> LEAK_SHIFT);
`else
        return v;
`endif
    endfunction

    // Model: ops applied in acceptance order to a plain array; writes/fires delayed
    bit m_init = 1, m_done = 0, m_next_chk = 1, m_post_rst = 1;
    int m_sweep = 0;
    int m_charge [DEPTH];
    bit w_v = 0, f1_v = 0, f_v = 0;
    int w_a = 0, w_d = 0, f1_a = 0, f_a = 0;

    always @(negedge clk) begin
        int g, a, c;
        bit contested;
        check("fire_valid", fire_valid, f_v);
        if (f_v) check("fire_addr", fire_addr, f_a);
        check("init_done", init_done, m_done);
        if (!reset) begin
            check("rst_wr_en", ram_wr_en, 0);
            check("rst_rd_en", ram_rd_en, 0);
            check("rst_acc_ready", acc_ready, 0);
            check("rst_chk_ready", chk_ready, 0);
            if (m_post_rst) begin
                check("rst_fire_addr", fire_addr, 0);
                check("rst_wr_addr", ram_wr_addr, 0);
                check("rst_wr_data", $signed(ram_wr_data), 0);
                check("rst_rd_addr", ram_rd_addr, 0);
            end
            m_init = 1; m_done = 0; m_next_chk = 1; m_post_rst = 1; m_sweep = 0;
            w_v = 0; f1_v = 0; f_v = 0;
        end else begin
            g = 0;
            contested = 0;
            if (!m_init) begin
                contested = acc_valid && chk_valid;
                if (contested) g = m_next_chk ? 2 : 1;
                else if (chk_valid) g = 2;
                else if (acc_valid) g = 1;
            end
            check("acc_ready", acc_ready, g == 1);
            check("chk_ready", chk_ready, g == 2);
            check("rd_en", ram_rd_en, g != 0);
            if (g == 1) check("rd_addr_acc", ram_rd_addr, acc_addr);
            if (g == 2) check("rd_addr_chk", ram_rd_addr, chk_addr);
            if (m_init) begin
                check("init_wr_en", ram_wr_en, 1);
                check("init_wr_addr", ram_wr_addr, m_sweep);
                check("init_wr_data", $signed(ram_wr_data), 0);
            end else begin
                check("wr_en", ram_wr_en, w_v);
                if (w_v) begin
                    check("wr_addr", ram_wr_addr, w_a);
                    check("wr_data", $signed(ram_wr_data), w_d);
                end
            end
            f_v = f1_v; f_a = f1_a; f1_v = 0; w_v = 0; m_post_rst = 0;
            if (m_init) begin
                if (m_sweep == DEPTH-1) begin
                    m_init = 0; m_done = 1;
                    foreach (m_charge[i]) m_charge[i] = 0;
                end else m_sweep++;
            end else if (g == 1) begin
                a = acc_addr;
                c = sat(m_charge[a] + int'(acc_weight));
                m_charge[a] = c; w_v = 1; w_a = a; w_d = c;
            end else if (g == 2) begin
                a = chk_addr;
                c = m_charge[a];
                if (c >= int'(chk_threshold)) begin
                    f1_v = 1; f1_a = a; c = 0;
                end else c = keep(c);
                m_charge[a] = c; w_v = 1; w_a = a; w_d = c;
            end
            if (contested) m_next_chk = !m_next_chk;
        end
    end

    int wlog_d [$];
    int fire_cnt = 0;
    always @(negedge clk) begin
        if (reset && init_done && ram_wr_en) wlog_d.push_back($signed(ram_wr_data));
        if (fire_valid) fire_cnt++;
    end

    task automatic drive(input bit av, input int aa, input int aw, input bit cv, input int ca, input int ct);
        @(posedge clk); #1;
        acc_valid = av; acc_addr = ADDR_W'(aa); acc_weight = WEIGHT_W'(aw);
        chk_valid = cv; chk_addr = ADDR_W'(ca); chk_threshold = DATA_W'(ct);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_init(output int writes);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (init_done) done = 1;
            else if (ram_wr_en) n++;
        end
        writes = n;
        check("init_timeout", done, 1);
    endtask

    initial begin
        int n, sa, sc;
        string seq;
        int acc5_exp [3] = '{10, 30, 27};
        reset = 0; acc_valid = 0; acc_addr = '0; acc_weight = '0;
        chk_valid = 0; chk_addr = '0; chk_threshold = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        wait_init(n);
        check("init_writes", n, 256);

        // contested requests alternate starting with check
        seq = ""; sa = 0; sc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 21, 1, 1, 20, 100);
            @(negedge clk);
            if (chk_ready) begin seq = {seq, "C"}; sc++; end
            else if (acc_ready) begin seq = {seq, "A"}; sa++; end
            else seq = {seq, "-"};
        end
        idle(3);
        checks++;
        if (seq != "CACACA") begin
            errors++;
            $display("FAIL grant_order: got %s, expected CACACA", seq);
        end
        check("grant_acc_count", sa, 3);
        check("grant_chk_count", sc, 3);

        // back-to-back accumulates on one address
        wlog_d.delete();
        drive(1, 5, 10, 0, 0, 0);
        drive(1, 5, 20, 0, 0, 0);
        drive(1, 5, -3, 0, 0, 0);
        idle(3);
        check("acc5_nwrites", wlog_d.size(), 3);
        for (int i = 0; i < 3; i++)
            check("acc5_write", (i < wlog_d.size()) ? wlog_d[i] : -99999, acc5_exp[i]);
        drive(1, 5, 0, 0, 0, 0);
        idle(2);
        check("acc5_reread", (wlog_d.size() == 4) ? wlog_d[3] : -99999, 27);
        check("acc5_mem", mem[5], 27);

        // saturation both ways
        repeat (300) drive(1, 7, 127, 0, 0, 0);
        idle(2);
        check("sat_pos", mem[7], 32767);
        repeat (600) drive(1, 7, -128, 0, 0, 0);
        idle(2);
        check("sat_neg", mem[7], -32768);

        // threshold equal fires, threshold above retains
        drive(1, 9, 40, 0, 0, 0);
        idle(2);
        n = fire_cnt;
        drive(0, 0, 0, 1, 9, 40);
        idle(2);
        @(negedge clk);
        check("fire_valid_n2", fire_valid, 1);
        check("fire_addr_n2", fire_addr, 9);
        idle(3);
        check("fire_clear_mem", mem[9], 0);
        check("fire_once", fire_cnt - n, 1);
        drive(1, 9, 40, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 1, 9, 41);
        idle(3);
        check("nofire_count", fire_cnt - n, 1);
`ifdef CHARGE_LEAK_EN
        check("nofire_keep", mem[9], 30);
`else
        check("nofire_keep", mem[9], 40);
`endif

        // random traffic on a few addresses to stress bypass and arbitration
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 600)) - 300);
        idle(2);

        // reset right after a firing check is accepted
        drive(1, 12, 50, 0, 0, 0);
        idle(2);
        n = fire_cnt;
        drive(0, 0, 0, 1, 12, 10);
        @(posedge clk); #1;
        reset = 0; chk_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        acc_valid = 1; acc_addr = 3; acc_weight = 1;
        chk_valid = 1; chk_addr = 4; chk_threshold = 100;
        check("rst_mid_nowrite", mem[12], 50);
        wait_init(n);
        check("rst_mid_init_writes", n, 256);
        n = fire_cnt;
        idle(4);
        check("rst_mid_nofire", fire_cnt - n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/charge_ram_ctrl.md
# charge_ram_ctrl

Sequencer and arbiter for the neuron charge dual-port RAM (16x256 read-before-write SRAM, 1-cycle registered read). It clears the RAM after reset and then shares the RAM between two requesters. The accumulate port performs saturating read-modify-write adds of synaptic weights. The check port compares charge against a threshold, emits a fire event and clears or retains the charge. It sits between the synapse dispatch logic and the charge RAM and sustains one operation per cycle, including back-to-back operations on the same address.

## Interface
Parameters:
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W
- DATA_W, 16, signed charge width
- WEIGHT_W, 8, signed weight width (≤ DATA_W)
- LEAK_SHIFT, 2, leak divisor exponent (used only with CHARGE_LEAK_EN)

Ports (reset: synchronous, active-low; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- acc_valid  in  1  accumulate request
- acc_ready  out  1  accumulate accepted this cycle
- acc_addr  in  ADDR_W  neuron address
- acc_weight  in  WEIGHT_W  signed weight
- chk_valid  in  1  check request
- chk_ready  out  1  check accepted this cycle
- chk_addr  in  ADDR_W  neuron address
- chk_threshold  in  DATA_W  signed threshold
- fire_valid  out  1  one-cycle fire pulse
- fire_addr  out  ADDR_W  address that fired
- init_done  out  1  RAM clear complete
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, valid cycle after ram_rd_en
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  ADDR_W  RAM write address
- ram_wr_data  out  DATA_W  RAM write data

## Operation
- States: INIT, RUN. reset low → INIT, sweep counter 0, pipeline valid bits cleared, round-robin pointer favours check.
- INIT: per cycle ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=0; counter increments. After writing address 2^ADDR_W−1 → RUN, init_done=1 (sticky until reset). acc_ready=chk_ready=0 in INIT.
- RUN arbitration: if only one valid, grant it; if both valid, alternate (round-robin pointer flips after each contested grant). Ready is asserted only for the granted port. Every grant is accepted; there is no stall source.
- Stage 0 (accept cycle): ram_rd_en=1, ram_rd_addr=request addr. Op, addr, weight/threshold registered into stage 1.
- Stage 1: operand = bypass value if bypass flag set, else ram_rd_data. Bypass flag is set when the stage-0 address equals the stage-1 write address in the same cycle; the bypass value is that write data.
- Accumulate: result = operand + sign-extended weight, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Check: if operand ≥ threshold (signed), write 0 and register fire. Otherwise write retained value (see Configuration).
- Stage 1 always drives ram_wr_en=1, ram_wr_addr, ram_wr_data.
- Reset mid-operation: in-flight ops are dropped without write, fire is not emitted, and the sweep restarts at 0.

## Timing
- Reset values: acc_ready 0, chk_ready 0, fire_valid 0, fire_addr 0, init_done 0, ram_rd_en 0, ram_wr_en 0, all address/data outputs 0. While reset is low, ram_wr_en=0.
- INIT lasts exactly 2^ADDR_W cycles after reset releases. init_done is high from the following cycle.
- Accept in cycle N: RAM read in N; write driven in N+1 and committed at the end of N+1; fire_valid/fire_addr high for exactly cycle N+2.
- Throughput: 1 op/cycle. Same-address ops in N and N+1 chain correctly through the bypass. A gap of ≥1 cycle reads the committed RAM value.

## Configuration
- CHARGE_LEAK_EN defined: non-firing check writes operand − (operand >>> LEAK_SHIFT), using an arithmetic shift.
- CHARGE_LEAK_EN undefined: non-firing check writes operand unchanged; LEAK_SHIFT is unused.

## Test plan
- Reset release → exactly 256 writes of 0 to addresses 0..255, then init_done=1. A request asserted during INIT sees ready=0.
- RUN, acc addr 5 with weights +10, +20, −3 on consecutive cycles → writes 10, 30, 27; a later RAM read of addr 5 returns 27 (exercises the bypass).
- Acc addr 7 weight +127 repeated 300 times → value saturates at 32767 and never wraps. Same test with −128 saturates at −32768.
- Charge 40 at addr 9; chk threshold 40 → write 0, fire_valid with fire_addr=9 two cycles after accept. Threshold 41 → no fire; write 40, or 30 with CHARGE_LEAK_EN.
- acc_valid and chk_valid held high for 6 cycles → grants alternate chk, acc, chk, acc, …; each requester is served 3 times.
- reset low one cycle after a chk accept that would fire → no fire_valid, no write, INIT restarts at address 0.
